// File: rtl/conv_window_source.sv
// Convolution window source: raster pixel stream in, KERNEL_SIZE x KERNEL_SIZE x IN_CHANNELS
// windows out over valid/ready, built from per-column line buffers and a shifting window register.
module conv_window_source #(
    parameter int IN_CHANNELS  = 3,
    parameter int KERNEL_SIZE  = 3,
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8,
    localparam int ActivationWidth = 9
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic                              slave_valid_i,
    output logic                              slave_ready_o,
    input  logic signed [ActivationWidth-1:0] slave_data_i [IN_CHANNELS],
    output logic                              master_valid_o,
    input  logic                              master_ready_i,
    output logic signed [ActivationWidth-1:0] master_data_o [KERNEL_SIZE][KERNEL_SIZE][IN_CHANNELS],
    output logic                              master_last_o
);

    localparam int XW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          accept;
    logic          x_last;
    logic          y_last;
    logic          window_ready;

    // line_buf[x][r]: the K-1 most recent rows at column x, r = 0 oldest
    logic signed [ActivationWidth-1:0] line_buf [IMAGE_WIDTH][KERNEL_SIZE-1][IN_CHANNELS];
    logic signed [ActivationWidth-1:0] new_col  [KERNEL_SIZE][IN_CHANNELS];

    always_comb begin
        slave_ready_o = !master_valid_o || master_ready_i;
        accept        = slave_valid_i && slave_ready_o;
        x_last        = (x == XW'(IMAGE_WIDTH - 1));
        y_last        = (y == YW'(IMAGE_HEIGHT - 1));
        window_ready  = (x >= XW'(KERNEL_SIZE - 1)) && (y >= YW'(KERNEL_SIZE - 1));
    end

    always_comb begin
        for (int unsigned r = 0; r < KERNEL_SIZE - 1; r++) begin
            new_col[r] = line_buf[x][r];
        end
        new_col[KERNEL_SIZE-1] = slave_data_i;
    end

    always_ff @(posedge clock_i) begin
        if (accept) begin
            for (int unsigned r = 0; r + 2 < KERNEL_SIZE; r++) begin
                line_buf[x][r] <= line_buf[x][r+1];
            end
            line_buf[x][KERNEL_SIZE-2] <= slave_data_i;
        end
    end

    // The window register doubles as the output register: it only shifts on accept,
    // and accept is blocked while a window is stalled, so the output holds stable.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            x              <= '0;
            y              <= '0;
            master_valid_o <= 1'b0;
            master_last_o  <= 1'b0;
            master_data_o  <= '{default: '0};
        end else if (accept) begin
            for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
                for (int unsigned j = 0; j + 1 < KERNEL_SIZE; j++) begin
                    master_data_o[i][j] <= master_data_o[i][j+1];
                end
                master_data_o[i][KERNEL_SIZE-1] <= new_col[i];
            end
            master_valid_o <= window_ready;
            master_last_o  <= x_last && y_last;
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end else if (master_ready_i) begin
            master_valid_o <= 1'b0;
            master_last_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_source.sv
// Directed bench for conv_window_source: a 4x4/K3/C1 instance for exact window sequences
// and a default 8x8/K3/C3 instance driven with random handshakes against a frame model.
module tb_conv_window_source;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic              s_svalid = 1'b0;
    logic              s_sready;
    logic              s_mvalid;
    logic              s_mready = 1'b1;
    logic              s_mlast;
    logic signed [8:0] s_din [1];
    logic signed [8:0] s_mdata [3][3][1];

    logic              b_svalid = 1'b0;
    logic              b_sready;
    logic              b_mvalid;
    logic              b_mready = 1'b1;
    logic              b_mlast;
    logic signed [8:0] b_din [3];
    logic signed [8:0] b_mdata [3][3][3];
    logic signed [8:0] bpix [64][3];

    conv_window_source #(
        .IN_CHANNELS(1), .KERNEL_SIZE(3), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)
    ) dut_small (
        .clock_i(clk), .reset_i(rst_n),
        .slave_valid_i(s_svalid), .slave_ready_o(s_sready), .slave_data_i(s_din),
        .master_valid_o(s_mvalid), .master_ready_i(s_mready),
        .master_data_o(s_mdata), .master_last_o(s_mlast)
    );

    conv_window_source #(
        .IN_CHANNELS(3), .KERNEL_SIZE(3), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8)
    ) dut_big (
        .clock_i(clk), .reset_i(rst_n),
        .slave_valid_i(b_svalid), .slave_ready_o(b_sready), .slave_data_i(b_din),
        .master_valid_o(b_mvalid), .master_ready_i(b_mready),
        .master_data_o(b_mdata), .master_last_o(b_mlast)
    );

    // window w of a 4x4 stream: frame w/4 (base 100*frame), top-left at ((w%4)%2, (w%4)/2)
    function automatic int small_exp(input int w, input int i, input int j);
        int f = w / 4;
        int k = w % 4;
        return 100 * f + 4 * (k / 2 + i) + (k % 2 + j);
    endfunction

    function automatic bit small_win_ok(input int w);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (s_mdata[i][j][0] !== 9'(small_exp(w, i, j))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit big_win_ok(input int w);
        int wy = w / 6;
        int wx = w % 6;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                for (int c = 0; c < 3; c++)
                    if (b_mdata[i][j][c] !== bpix[(wy + i) * 8 + wx + j][c]) return 1'b0;
        return 1'b1;
    endfunction

    // Streams `frames` 4x4 frames (pixel = 100*frame + 4y + x) into the small DUT,
    // optionally holding master_ready low for `stall` cycles once the first window appears.
    task automatic stream_small(input int frames, input int stall, output int nwin);
        int  sent = 0;
        int  total = frames * 16;
        int  w = 0;
        int  cyc = 0;
        int  stall_left = stall;
        bit  stalled;
        while ((sent < total || s_mvalid) && cyc < 400) begin
            s_svalid  = (sent < total);
            s_din[0]  = 9'(100 * (sent / 16) + sent % 16);
            stalled   = (stall_left > 0) && s_mvalid;
            s_mready  = !stalled;
            if (stalled) stall_left--;
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (s_sready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: slave_ready_o=%b required 0", s_sready);
                end
                checks++;
                if (!small_win_ok(w)) begin
                    errors++;
                    $display("FAIL stall_hold: tl=%0d br=%0d required tl=%0d br=%0d",
                             s_mdata[0][0][0], s_mdata[2][2][0], small_exp(w, 0, 0), small_exp(w, 2, 2));
                end
            end
            if (s_mvalid && s_mready) begin
                checks++;
                if (!small_win_ok(w)) begin
                    errors++;
                    $display("FAIL window%0d: tl=%0d mid=%0d br=%0d required tl=%0d mid=%0d br=%0d", w,
                             s_mdata[0][0][0], s_mdata[1][1][0], s_mdata[2][2][0],
                             small_exp(w, 0, 0), small_exp(w, 1, 1), small_exp(w, 2, 2));
                end
                checks++;
                if (s_mlast !== ((w % 4) == 3)) begin
                    errors++;
                    $display("FAIL last%0d: master_last_o=%b required %b", w, s_mlast, (w % 4) == 3);
                end
                w++;
            end
            if (s_svalid && s_sready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 400) begin
            errors++;
            $display("FAIL timeout_small: sent %0d pixels, required %0d", sent, total);
        end
        s_svalid = 1'b0;
        s_mready = 1'b1;
        nwin = w;
    endtask

    task automatic test_reset;
        checks++;
        if (s_mvalid !== 1'b0 || s_mlast !== 1'b0 || s_sready !== 1'b1) begin
            errors++;
            $display("FAIL reset_small: valid=%b last=%b ready=%b required 0 0 1", s_mvalid, s_mlast, s_sready);
        end
        checks++;
        if (s_mdata[0][0][0] !== 9'sd0 || s_mdata[2][2][0] !== 9'sd0) begin
            errors++;
            $display("FAIL reset_small_data: tl=%0d br=%0d required 0 0", s_mdata[0][0][0], s_mdata[2][2][0]);
        end
        checks++;
        if (b_mvalid !== 1'b0 || b_mlast !== 1'b0 || b_mdata[1][2][2] !== 9'sd0) begin
            errors++;
            $display("FAIL reset_big: valid=%b last=%b d=%0d required 0 0 0", b_mvalid, b_mlast, b_mdata[1][2][2]);
        end
    endtask

    task automatic test_single_frame;
        int n;
        stream_small(1, 0, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL count_single: windows=%0d required 4", n);
        end
    endtask

    task automatic test_stall;
        int n;
        stream_small(1, 5, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL count_stall: windows=%0d required 4", n);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        stream_small(2, 0, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL count_b2b: windows=%0d required 8", n);
        end
    endtask

    task automatic test_async_reset;
        int sent = 0;
        int cyc = 0;
        int n;
        // pixels 0..10 so the first window is sitting in the output register
        while (sent < 11 && cyc < 50) begin
            s_svalid = 1'b1;
            s_din[0] = 9'(sent);
            @(negedge clk);
            if (s_sready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_svalid = 1'b0;
        checks++;
        if (s_mvalid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: master_valid_o=%b required 1", s_mvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (s_mvalid !== 1'b0 || s_mlast !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b last=%b required 0 0", s_mvalid, s_mlast);
        end
        checks++;
        if (s_mdata[2][2][0] !== 9'sd0 || s_mdata[0][0][0] !== 9'sd0) begin
            errors++;
            $display("FAIL async_reset_data: tl=%0d br=%0d required 0 0", s_mdata[0][0][0], s_mdata[2][2][0]);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        stream_small(1, 0, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL count_after_reset: windows=%0d required 4", n);
        end
    endtask

    task automatic test_random_default;
        int sent = 0;
        int w = 0;
        int cyc = 0;
        for (int p = 0; p < 64; p++)
            for (int c = 0; c < 3; c++)
                bpix[p][c] = 9'($urandom_range(0, 511));
        bpix[0][0]  = -9'sd256;
        bpix[27][1] = 9'sd255;
        bpix[63][2] = 9'sd255;
        bpix[36][0] = -9'sd1;
        while ((sent < 64 || b_mvalid) && cyc < 3000) begin
            b_svalid = (sent < 64) && ($urandom_range(0, 3) != 0);
            b_mready = ($urandom_range(0, 2) != 0);
            b_din    = bpix[sent % 64];
            @(negedge clk);
            if (b_mvalid && b_mready) begin
                checks++;
                if (!big_win_ok(w)) begin
                    errors++;
                    $display("FAIL big_window%0d: tl=%0d br=%0d required tl=%0d br=%0d", w,
                             b_mdata[0][0][0], b_mdata[2][2][2],
                             bpix[(w / 6) * 8 + w % 6][0], bpix[(w / 6 + 2) * 8 + w % 6 + 2][2]);
                end
                checks++;
                if (b_mlast !== (w == 35)) begin
                    errors++;
                    $display("FAIL big_last%0d: master_last_o=%b required %b", w, b_mlast, w == 35);
                end
                w++;
            end
            if (b_svalid && b_sready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        b_svalid = 1'b0;
        b_mready = 1'b1;
        checks++;
        if (w !== 36 || cyc >= 3000) begin
            errors++;
            $display("FAIL big_count: windows=%0d required 36 (cycles %0d)", w, cyc);
        end
    endtask

    initial begin
        s_din[0] = '0;
        b_din    = '{default: '0};
        #12;
        test_reset;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_single_frame;
        test_stall;
        test_back_to_back;
        test_async_reset;
        test_random_default;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
